// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA timing generator. Divides the system clock to a
//            pixel-rate tick, runs horizontal/vertical counters and produces
//            sync pulses, active-video flags, line/frame strobes and a frame
//            counter for game-logic pacing.
// Ports    : clock, reset (sync, active-high), enable (run/freeze)
//            pix_en            one-clock pixel tick
//            hcount, vcount    current pixel column / line
//            h_video_on, v_video_on, video_on   active-video flags
//            vga_hs, vga_vs    sync outputs, polarity set by HS_POL/VS_POL
//            line_end, frame_end   last-pixel-tick strobes
//            frame_count       completed-frame counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             h_video_on,
    output logic             v_video_on,
    output logic             video_on,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             line_end,
    output logic             frame_end,
    output logic [7:0]       frame_count
);

    localparam int c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_start   = H_ACTIVE + H_FP;
    localparam int c_hs_end     = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int c_vs_start   = V_ACTIVE + V_FP;
    localparam int c_vs_end     = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int c_div_w      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_tick;     // pixel tick pending in this cycle
    logic               r_h_last;   // hcount == H_TOTAL-1
    logic               r_v_last;   // vcount == V_TOTAL-1
    logic [CNT_W-1:0]   w_h_next;
    logic [CNT_W-1:0]   w_v_next;
    logic               w_div_last;

    assign w_div_last = (r_div_cnt == c_div_w'(CLK_DIV - 1));

    // Next counter position; flags and syncs are computed from it so they are
    // registered alongside the counters and always match the displayed value.
    always_comb begin
        w_h_next = hcount + 1'b1;
        w_v_next = vcount;
        if (r_h_last) begin
            w_h_next = '0;
            w_v_next = r_v_last ? '0 : vcount + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_tick      <= 1'b0;
            r_h_last    <= 1'b0;
            r_v_last    <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            h_video_on  <= 1'b1;
            v_video_on  <= 1'b1;
            video_on    <= 1'b1;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            frame_count <= '0;
        end else if (enable) begin
            r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
            r_tick    <= w_div_last;
            if (r_tick) begin
                hcount     <= w_h_next;
                vcount     <= w_v_next;
                r_h_last   <= (w_h_next == CNT_W'(c_h_total - 1));
                r_v_last   <= (w_v_next == CNT_W'(c_v_total - 1));
                h_video_on <= (w_h_next < CNT_W'(H_ACTIVE));
                v_video_on <= (w_v_next < CNT_W'(V_ACTIVE));
                video_on   <= (w_h_next < CNT_W'(H_ACTIVE)) &&
                              (w_v_next < CNT_W'(V_ACTIVE));
                vga_hs     <= ((w_h_next >= CNT_W'(c_hs_start)) &&
                               (w_h_next <= CNT_W'(c_hs_end))) ? HS_POL : ~HS_POL;
                vga_vs     <= ((w_v_next >= CNT_W'(c_vs_start)) &&
                               (w_v_next <= CNT_W'(c_vs_end))) ? VS_POL : ~VS_POL;
                if (r_h_last && r_v_last) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    // A tick that is pending when enable drops is held in r_tick and shown
    // on resume, so freezing never skips or duplicates a pixel.
    assign pix_en    = r_tick & enable;
    assign line_end  = pix_en & r_h_last;
    assign frame_end = line_end & r_v_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. Three instances (default
//            640x480, a tiny 16x7 raster at CLK_DIV=1, a small raster at
//            CLK_DIV=3 with randomly gated enable) are compared each cycle
//            against an arithmetic model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pix;
        logic [15:0] h;
        logic [15:0] v;
        logic        hvo;
        logic        vvo;
        logic        vo;
        logic        hs;
        logic        vs;
        logic        le;
        logic        fe;
        logic [7:0]  fc;
    } vga_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- DUT 0: defaults ----------------
    logic rst0 = 1'b1, en0 = 1'b1;
    logic d0_pix, d0_hvo, d0_vvo, d0_vo, d0_hs, d0_vs, d0_le, d0_fe;
    logic [15:0] d0_h, d0_v;
    logic [7:0]  d0_fc;
    vga_timing_gen u_d0 (
        .clock(clk), .reset(rst0), .enable(en0), .pix_en(d0_pix),
        .hcount(d0_h), .vcount(d0_v), .h_video_on(d0_hvo), .v_video_on(d0_vvo),
        .video_on(d0_vo), .vga_hs(d0_hs), .vga_vs(d0_vs), .line_end(d0_le),
        .frame_end(d0_fe), .frame_count(d0_fc));

    // ---------------- DUT 1: tiny raster, CLK_DIV=1, HS active-high -------
    logic rst1 = 1'b1, en1 = 1'b1;
    logic d1_pix, d1_hvo, d1_vvo, d1_vo, d1_hs, d1_vs, d1_le, d1_fe;
    logic [15:0] d1_h, d1_v;
    logic [7:0]  d1_fc;
    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_d1 (
        .clock(clk), .reset(rst1), .enable(en1), .pix_en(d1_pix),
        .hcount(d1_h), .vcount(d1_v), .h_video_on(d1_hvo), .v_video_on(d1_vvo),
        .video_on(d1_vo), .vga_hs(d1_hs), .vga_vs(d1_vs), .line_end(d1_le),
        .frame_end(d1_fe), .frame_count(d1_fc));

    // ---------------- DUT 2: CLK_DIV=3, VS active-high, random enable -----
    logic rst2 = 1'b1, en2 = 1'b1;
    logic d2_pix, d2_hvo, d2_vvo, d2_vo, d2_hs, d2_vs, d2_le, d2_fe;
    logic [15:0] d2_h, d2_v;
    logic [7:0]  d2_fc;
    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_d2 (
        .clock(clk), .reset(rst2), .enable(en2), .pix_en(d2_pix),
        .hcount(d2_h), .vcount(d2_v), .h_video_on(d2_hvo), .v_video_on(d2_vvo),
        .video_on(d2_vo), .vga_hs(d2_hs), .vga_vs(d2_vs), .line_end(d2_le),
        .frame_end(d2_fe), .frame_count(d2_fc));

    vga_t a0, a1, a2;
    assign a0 = {d0_pix, d0_h, d0_v, d0_hvo, d0_vvo, d0_vo, d0_hs, d0_vs, d0_le, d0_fe, d0_fc};
    assign a1 = {d1_pix, d1_h, d1_v, d1_hvo, d1_vvo, d1_vo, d1_hs, d1_vs, d1_le, d1_fe, d1_fc};
    assign a2 = {d2_pix, d2_h, d2_v, d2_hvo, d2_vvo, d2_vo, d2_hs, d2_vs, d2_le, d2_fe, d2_fc};

    // Model: e = enabled clock edges since reset. The pixel tick is visible
    // every CLK_DIV-th enabled edge; each visible tick advances the raster by
    // one pixel on the following enabled edge, so n = (e-1)/div pixels done.
    function automatic vga_t model(input int div, ha, hfp, hsw, hbp,
                                   input int va, vfp, vsw, vbp,
                                   input bit hpol, vpol, input int e, input bit en);
        vga_t m;
        int ht, vt, n, h, v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        n  = (e == 0) ? 0 : (e - 1) / div;
        h  = n % ht;
        v  = (n / ht) % vt;
        m.pix = en && (e > 0) && (e % div == 0);
        m.h   = 16'(h);
        m.v   = 16'(v);
        m.hvo = (h < ha);
        m.vvo = (v < va);
        m.vo  = (h < ha) && (v < va);
        m.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
        m.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
        m.le  = m.pix && (h == ht - 1);
        m.fe  = m.le && (v == vt - 1);
        m.fc  = 8'((n / (ht * vt)) % 256);
        return m;
    endfunction

    task automatic cmp(input string nm, input vga_t act, input vga_t ex);
        n_assert++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s t=%0t act pix=%b h=%0d v=%0d hvo/vvo/vo=%b%b%b hs/vs=%b%b le/fe=%b%b fc=%0d exp pix=%b h=%0d v=%0d hvo/vvo/vo=%b%b%b hs/vs=%b%b le/fe=%b%b fc=%0d",
                     nm, $time, act.pix, act.h, act.v, act.hvo, act.vvo, act.vo, act.hs, act.vs,
                     act.le, act.fe, act.fc, ex.pix, ex.h, ex.v, ex.hvo, ex.vvo, ex.vo, ex.hs,
                     ex.vs, ex.le, ex.fe, ex.fc);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint ex);
        n_assert++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, ex);
        end
    endtask

    int  e0 = 0, e1 = 0, e2 = 0;
    bit  v0 = 0, v1 = 0, v2 = 0;

    always @(posedge clk) begin
        if (rst0) begin e0 <= 0; v0 <= 1'b1; end else if (en0) e0 <= e0 + 1;
        if (rst1) begin e1 <= 0; v1 <= 1'b1; end else if (en1) e1 <= e1 + 1;
        if (rst2) begin e2 <= 0; v2 <= 1'b1; end else if (en2) e2 <= e2 + 1;
    end

    always @(negedge clk) begin
        if (v0) cmp("model_d0", a0, model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, e0, en0));
        if (v1) cmp("model_d1", a1, model(1, 8, 2, 3, 3, 4, 1, 1, 1, 1'b1, 1'b0, e1, en1));
        if (v2) cmp("model_d2", a2, model(3, 20, 2, 4, 3, 6, 1, 2, 2, 1'b0, 1'b1, e2, en2));
    end

    // DUT 2 sees an enable that is low roughly a quarter of the time.
    initial begin
        forever begin
            @(negedge clk);
            #1 if (!rst2) en2 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int cnt, hs_low, le_cnt, le_h, k;

        // ---- reset held 5 clocks, enable high (reset wins) ----
        repeat (5) @(negedge clk);
        chk("rst_hs", d0_hs, 1);
        chk("rst_vs", d0_vs, 1);
        chk("rst_video_on", d0_vo, 1);
        chk("rst_pix_en", d0_pix, 0);
        chk("rst_hcount", d0_h, 0);
        chk("rst_d1_hs", d1_hs, 0);
        #1 begin rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; end

        // ---- first pixel tick CLK_DIV clocks after release ----
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!d0_pix && cnt < 20);
        chk("first_pix_latency", cnt, 4);

        // ---- one line at defaults ----
        for (k = 0; k < 4000 && d0_h != 640; k++) @(negedge clk);
        chk("wait_h640", d0_h, 640);
        chk("hvo_at_640", d0_hvo, 0);
        chk("vo_at_640", d0_vo, 0);
        hs_low = 0; le_cnt = 0; le_h = -1;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!d0_hs) hs_low++;
            if (d0_le) begin le_cnt++; le_h = d0_h; end
            if (d0_h == 0) break;
        end
        chk("hs_low_clocks", hs_low, 384);
        chk("line_end_count", le_cnt, 1);
        chk("line_end_hcount", le_h, 799);
        chk("wrap_hcount", d0_h, 0);
        chk("wrap_vcount", d0_v, 1);

        // ---- freeze mid-divide at hcount=700 ----
        for (k = 0; k < 3000 && d0_h != 700; k++) @(negedge clk);
        chk("wait_h700", d0_h, 700);
        #1 en0 = 1'b0;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (d0_pix || d0_le) cnt++; end
        chk("freeze_no_ticks", cnt, 0);
        chk("freeze_hcount", d0_h, 700);
        #1 en0 = 1'b1;
        @(negedge clk); chk("resume_pix1", d0_pix, 0);
        @(negedge clk); chk("resume_pix2", d0_pix, 0);
        @(negedge clk); chk("resume_pix3", d0_pix, 1);
        chk("resume_h_before", d0_h, 700);
        @(negedge clk); chk("resume_h_after", d0_h, 701);

        // ---- reset coincident with a pixel tick ----
        for (k = 0; k < 8 && !d0_pix; k++) @(negedge clk);
        chk("d0_pix_before_rst", d0_pix, 1);
        #1 rst0 = 1'b1;
        @(negedge clk);
        chk("d0_rst_h", d0_h, 0);
        chk("d0_rst_v", d0_v, 0);
        chk("d0_rst_fc", d0_fc, 0);
        chk("d0_rst_hs", d0_hs, 1);
        chk("d0_rst_vs", d0_vs, 1);
        chk("d0_rst_pix", d0_pix, 0);
        #1 rst0 = 1'b0;

        // ---- tiny raster: hsync window, frame period, reset, wrap ----
        for (k = 0; k < 40 && d1_h != 9; k++) @(negedge clk);
        chk("d1_hs_at9", d1_hs, 0);
        @(negedge clk); chk("d1_hs_at10", d1_hs, 1);
        @(negedge clk);
        @(negedge clk); chk("d1_hs_at12", d1_hs, 1);
        @(negedge clk); chk("d1_hs_at13", d1_hs, 0);
        for (k = 0; k < 200 && !d1_fe; k++) @(negedge clk);
        chk("d1_fe_h", d1_h, 15);
        chk("d1_fe_v", d1_v, 6);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!d1_fe && cnt < 300);
        chk("d1_frame_period", cnt, 112);
        for (k = 0; k < 200 && !(d1_h == 5 && d1_v == 3); k++) @(negedge clk);
        chk("d1_pix_before_rst", d1_pix, 1);
        chk("d1_fc_nonzero", (d1_fc != 0), 1);
        #1 rst1 = 1'b1;
        @(negedge clk);
        chk("d1_rst_h", d1_h, 0);
        chk("d1_rst_v", d1_v, 0);
        chk("d1_rst_fc", d1_fc, 0);
        chk("d1_rst_hs", d1_hs, 0);
        chk("d1_rst_pix", d1_pix, 0);
        #1 rst1 = 1'b0;
        for (k = 0; k < 256 * 112 + 500 && d1_fc != 255; k++) @(negedge clk);
        chk("d1_fc_reach255", d1_fc, 255);
        for (k = 0; k < 300 && d1_fc == 255; k++) @(negedge clk);
        chk("d1_fc_wrap", d1_fc, 0);
        chk("d1_wrap_h", d1_h, 0);
        chk("d1_wrap_v", d1_v, 0);

        // ---- active-high vsync window on DUT 2 ----
        for (k = 0; k < 6000 && d2_v != 7; k++) @(negedge clk);
        chk("d2_vs_at7", d2_vs, 1);
        for (k = 0; k < 6000 && d2_v != 9; k++) @(negedge clk);
        chk("d2_vs_at9", d2_vs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that replaces the fixed 640x480 sync logic in the Pong top level. It divides the system clock down to a pixel-rate enable and runs the horizontal and vertical counters. It produces sync pulses with configurable polarity, the active-video flags, and per-line and per-frame strobes plus a frame counter for game-logic pacing. The pixel renderer and paddle/ball logic sit downstream, all running on the same single clock and gated by pix_en.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of vga_hs (0 = active-low)
VS_POL, 0, active level of vga_vs
CNT_W, 16, width of hcount/vcount

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run/freeze; low holds all state, pix_en forced 0
pix_en  out  1  one-clock pixel tick
hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
vcount  out  CNT_W  current line, 0..V_TOTAL-1
h_video_on  out  1  hcount < H_ACTIVE
v_video_on  out  1  vcount < V_ACTIVE
video_on  out  1  h_video_on & v_video_on
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
line_end  out  1  strobe on last pixel tick of a line
frame_end  out  1  strobe on last pixel tick of a frame
frame_count  out  8  completed-frame counter, wraps

Behaviour:
- One clock (clock); reset is synchronous and active-high. Reset has priority over enable.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- Reset values:
  - div_cnt=0, hcount=0, vcount=0, pix_en=0, line_end=0, frame_end=0, frame_count=0.
  - h_video_on=v_video_on=video_on=1.
  - vga_hs=~HS_POL, vga_vs=~VS_POL (both inactive).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1.
  - pix_en=1 for exactly one clock when div_cnt==CLK_DIV-1. Period is CLK_DIV clocks.
  - CLK_DIV=1: pix_en=1 every enabled clock.
  - First pix_en after reset release (enable=1) occurs CLK_DIV clocks later.
- Counters advance only on pix_en:
  - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 on the same tick as hcount wraps.
- All flags and syncs are registered and updated on the same edge as the counters, so they always describe the hcount/vcount value presented in that cycle (zero relative latency, glitch-free).
- vga_hs = HS_POL while H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 at defaults), else ~HS_POL.
- vga_vs = VS_POL while V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 at defaults), else ~VS_POL.
- Strobes:
  - line_end=1 in the cycle where pix_en=1 and hcount==H_TOTAL-1, else 0.
  - frame_end=1 in the cycle where pix_en=1, hcount==H_TOTAL-1 and vcount==V_TOTAL-1. It coincides with a line_end.
- frame_count increments (mod 256) on the edge following frame_end, i.e. together with the counter wrap to (0,0).
- enable=0:
  - div_cnt, hcount, vcount, syncs, flags and frame_count hold.
  - pix_en, line_end and frame_end are 0.
  - Resuming enable continues from the held div_cnt with no extra tick.
- Reset mid-frame: the next edge returns every output to its reset value regardless of enable or pix_en. Counting restarts from (0,0).
- Widths: CNT_W must hold H_TOTAL-1 and V_TOTAL-1. Compares are unsigned. No other arithmetic overflow is possible.

Test Plan:
- Reset held 5 clocks, then enable=1 at defaults -> during reset all outputs at reset values (vga_hs=vga_vs=1, video_on=1); pix_en first high 4 clocks after release, then every 4th clock.
- Run one line at defaults -> h_video_on falls at hcount=640; vga_hs low exactly for hcount 656..751 (96 ticks = 384 clocks); line_end pulses once at hcount=799; next cycle hcount=0, vcount=1.
- Run one full frame (420000 pix ticks) -> vga_vs low only for vcount 490..491; frame_end single pulse at (799,524); frame_count 0->1; counters back at (0,0).
- Parameter override CLK_DIV=1, HS_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> pix_en constant 1; vga_hs high for hcount 10..12; H_TOTAL=16, V_TOTAL=7; frame_end every 112 clocks; frame_count wraps 255->0 after 256 frames.
- Drop enable for 10 clocks at hcount=700 mid-divide -> all outputs frozen, no pix_en/strobes; on resume the remaining divider count completes before the next tick and no pixel is skipped or repeated.
- Assert reset for 1 clock at (300,200) with enable=1 and pix_en=1 coincident -> next cycle hcount=vcount=0, frame_count=0, syncs inactive, pix_en=0.
